// File: rtl/sipo_rx.sv
// Serial-in/parallel-out deserializer: one bit per serial handshake, WIDTH-bit words out on valid/ready.
// Optional even-parity bit per frame and perr_o output when SIPO_PARITY_EN is defined.
module sipo_rx #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             sdata_i,
   input  logic             svalid_i,
   output logic             sready_o,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i
`ifdef SIPO_PARITY_EN
   ,output logic            perr_o
`endif
);

`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   typedef enum logic {S_SHIFT, S_PEND} state_t;

   state_t           state_q, state_d;
   logic             alive_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d, word_nxt;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             accept, free;
`ifdef SIPO_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif

   // State register; alive_q holds sready_o low until the first edge after reset release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_SHIFT;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef SIPO_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // Shift register with the incoming bit dropped into its slot; a parity beat matches no slot.
   always_comb begin
      word_nxt = shreg_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (LSB_FIRST ? (cnt_q == CW'(i)) : (cnt_q == CW'(WIDTH - 1 - i)))
            word_nxt[i] = sdata_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
`ifdef SIPO_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif
      if (valid_q && ready_i)
         valid_d = 1'b0;
      // Clear only discards assembly state; a presented word waits for its consumer.
      if (clear_i) begin
         state_d = S_SHIFT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (accept) begin
                  if (cnt_q != LAST) begin
                     shreg_d = word_nxt;
                     cnt_d   = cnt_q + CW'(1);
                  end else begin
                     cnt_d = '0;
                     if (free) begin
`ifdef SIPO_PARITY_EN
                        data_d = shreg_q;
                        perr_d = (^shreg_q) ^ sdata_i;
`else
                        data_d = word_nxt;
`endif
                        valid_d = 1'b1;
                     end else begin
`ifdef SIPO_PARITY_EN
                        par_d = sdata_i;
`else
                        shreg_d = word_nxt;
`endif
                        state_d = S_PEND;
                     end
                  end
               end
            end
            S_PEND: begin
               if (ready_i) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                  perr_d  = (^shreg_q) ^ par_q;
`endif
                  state_d = S_SHIFT;
               end
            end
            default: state_d = S_SHIFT;
         endcase
      end
   end

   assign sready_o = alive_q && (state_q == S_SHIFT);
   assign accept   = svalid_i && sready_o;
   assign free     = !valid_q || ready_i;
   assign data_o   = data_q;
   assign valid_o  = valid_q;
`ifdef SIPO_PARITY_EN
   assign perr_o   = perr_q;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: LSB-first and MSB-first instances share one serial stream.
// Parity checks are compiled in when SIPO_PARITY_EN is defined.
module tb_sipo_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       sdata = 1'b0;
   logic       svalid = 1'b0;
   logic       ready = 1'b0;
   logic       sready_l, sready_m;
   logic [7:0] data_l, data_m;
   logic       valid_l, valid_m;
`ifdef SIPO_PARITY_EN
   logic       perr_l, perr_m;
`endif
   int         errs = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .sdata_i(sdata), .svalid_i(svalid),
      .sready_o(sready_l), .data_o(data_l), .valid_o(valid_l), .ready_i(ready)
`ifdef SIPO_PARITY_EN
      , .perr_o(perr_l)
`endif
   );

   sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .sdata_i(sdata), .svalid_i(svalid),
      .sready_o(sready_m), .data_o(data_m), .valid_o(valid_m), .ready_i(ready)
`ifdef SIPO_PARITY_EN
      , .perr_o(perr_m)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bits go out w[0] first; with parity enabled a ninth bit pbit follows.
   task automatic send_word(input logic [7:0] w, input logic pbit);
      for (int i = 0; i < 8; i++) begin
         sdata  = w[i];
         svalid = 1'b1;
         tick();
      end
`ifdef SIPO_PARITY_EN
      sdata = pbit;
      tick();
`else
      if (pbit) sdata = 1'b0;
`endif
      svalid = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      chk("rst_valid", {31'd0, valid_l}, 32'd0);
      chk("rst_data", {24'd0, data_l}, 32'd0);
      chk("rst_sready", {31'd0, sready_l}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("sready_after_rst", {31'd0, sready_l}, 32'd1);

      // Basic word, one-cycle valid
      ready = 1'b1;
      send_word(8'hA5, 1'b0);
      chk("a5_valid", {31'd0, valid_l}, 32'd1);
      chk("a5_lsb", {24'd0, data_l}, 32'hA5);
      chk("a5_msb", {24'd0, data_m}, 32'hA5);
      tick();
      chk("a5_valid_drop", {31'd0, valid_l}, 32'd0);

      // Bit order: 1,1,0,0,0,0,0,0
      send_word(8'h03, 1'b0);
      chk("03_lsb", {24'd0, data_l}, 32'h03);
      chk("c0_msb", {24'd0, data_m}, 32'hC0);
      tick();

      // Backpressure: second word parks in S_PEND
      ready = 1'b0;
      send_word(8'h3C, 1'b0);
      chk("bp_first_valid", {31'd0, valid_l}, 32'd1);
      chk("bp_first_data", {24'd0, data_l}, 32'h3C);
      chk("bp_sready_shift", {31'd0, sready_l}, 32'd1);
      send_word(8'h81, 1'b0);
      chk("bp_sready_pend", {31'd0, sready_l}, 32'd0);
      chk("bp_hold_data", {24'd0, data_l}, 32'h3C);
      svalid = 1'b1; sdata = 1'b1;
      tick();
      tick();
      chk("bp_hold_sready", {31'd0, sready_l}, 32'd0);
      chk("bp_hold_valid", {31'd0, valid_l}, 32'd1);
      svalid = 1'b0;
      ready = 1'b1;
      tick();
      chk("bp_second_valid", {31'd0, valid_l}, 32'd1);
      chk("bp_second_data", {24'd0, data_l}, 32'h81);
      chk("bp_second_msb", {24'd0, data_m}, 32'h81);
      chk("bp_sready_back", {31'd0, sready_l}, 32'd1);
      tick();
      chk("bp_drained", {31'd0, valid_l}, 32'd0);

      // Clear mid-frame drops the partial word and the coincident bit
      for (int i = 0; i < 5; i++) begin
         sdata = 1'b1; svalid = 1'b1;
         tick();
      end
      clear = 1'b1;
      tick();
      clear = 1'b0; svalid = 1'b0;
      chk("clr_no_word", {31'd0, valid_l}, 32'd0);
      ready = 1'b0;
      send_word(8'h5A, 1'b0);
      chk("clr_5a_lsb", {24'd0, data_l}, 32'h5A);
      chk("clr_5a_msb", {24'd0, data_m}, 32'h5A);
      // Clear leaves a presented word in place
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_keeps_valid", {31'd0, valid_l}, 32'd1);
      chk("clr_keeps_data", {24'd0, data_l}, 32'h5A);
      ready = 1'b1;
      tick();
      chk("clr_consumed", {31'd0, valid_l}, 32'd0);

      // Async reset mid-frame with a word presented
      ready = 1'b0;
      send_word(8'h0F, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sdata = 1'b1; svalid = 1'b1;
         tick();
      end
      svalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, valid_l}, 32'd0);
      chk("arst_data", {24'd0, data_l}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      ready = 1'b1;
      send_word(8'hFF, 1'b0);
      chk("arst_ff_valid", {31'd0, valid_l}, 32'd1);
      chk("arst_ff_data", {24'd0, data_l}, 32'hFF);
      tick();

`ifdef SIPO_PARITY_EN
      send_word(8'hA5, 1'b0);
      chk("par_ok_data", {24'd0, data_l}, 32'hA5);
      chk("par_ok_perr", {31'd0, perr_l}, 32'd0);
      tick();
      send_word(8'hA5, 1'b1);
      chk("par_bad_data", {24'd0, data_l}, 32'hA5);
      chk("par_bad_perr", {31'd0, perr_l}, 32'd1);
      chk("par_bad_perr_msb", {31'd0, perr_m}, 32'd1);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
